// File: rtl/dcm_reset_ctrl_if.sv
// ---------------------------------------------------------------------------
// dcm_reset_ctrl_if
// Groups the DCM status inputs, the restart request and the reset/status
// outputs of dcm_reset_ctrl.
//   dcm_locked    : DCM LOCKED flag, asynchronous to the controller clock
//   clkin_stopped : DCM clock-input-stopped flag, asynchronous
//   restart       : single-cycle synchronous request to restart the sequence
//   dcm_rst       : DCM RST drive, high holds the DCM in reset
//   sys_reset     : active-high reset for the DCM-clocked system
//   ready         : high only while the DCM is locked and released
//   fault         : high only after lock attempts are exhausted
//   loss_count    : saturating count of lock losses seen while running
// The slave modport is the controller side; master is its environment.
// ---------------------------------------------------------------------------
interface dcm_reset_ctrl_if;
    logic       dcm_locked;
    logic       clkin_stopped;
    logic       restart;
    logic       dcm_rst;
    logic       sys_reset;
    logic       ready;
    logic       fault;
    logic [7:0] loss_count;

    modport master (
        output dcm_locked,
        output clkin_stopped,
        output restart,
        input  dcm_rst,
        input  sys_reset,
        input  ready,
        input  fault,
        input  loss_count
    );

    modport slave (
        input  dcm_locked,
        input  clkin_stopped,
        input  restart,
        output dcm_rst,
        output sys_reset,
        output ready,
        output fault,
        output loss_count
    );
endinterface

// File: rtl/dcm_reset_ctrl.sv
// ---------------------------------------------------------------------------
// dcm_reset_ctrl
// Sequences a DCM out of reset: pulses dcm_rst, waits for lock with a
// timeout and a bounded number of retries, requires lock to stay stable
// before releasing the system, and restarts on any lock loss or stopped
// input clock. Exhausted retries park the block in a fault state.
// Ports:
//   clock   : DCM input reference clock, all logic on its rising edge
//   reset_n : asynchronous active-low reset
//   bus     : dcm_reset_ctrl_if.slave (status inputs, restart, outputs)
// Parameters:
//   RST_CYCLES    : cycles dcm_rst is held per DCM reset (3..255)
//   LOCK_TIMEOUT  : cycles allowed for lock after dcm_rst falls (2..65536)
//   STABLE_CYCLES : cycles lock must stay high before release (1..65536)
//   MAX_RETRIES   : timed-out attempts allowed before fault (0..15)
// ---------------------------------------------------------------------------
module dcm_reset_ctrl #(
    parameter int RST_CYCLES    = 4,
    parameter int LOCK_TIMEOUT  = 1024,
    parameter int STABLE_CYCLES = 16,
    parameter int MAX_RETRIES   = 7
) (
    input  logic             clock,
    input  logic             reset_n,
    dcm_reset_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        RESET_DCM,
        WAIT_LOCK,
        SETTLE,
        RUN,
        FAULT
    } state_t;

    localparam logic [15:0] RST_LAST    = 16'(RST_CYCLES - 1);
    localparam logic [15:0] LOCK_LAST   = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
    localparam logic [3:0]  RETRY_MAX   = 4'(MAX_RETRIES);

    state_t      state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [3:0]  retries_reg, retries_next;
    logic [7:0]  loss_reg, loss_next;

    logic        locked_meta_reg, locked_s;
    logic        stop_meta_reg, stop_s;
    logic        lock_ok;

    logic        dcm_rst_reg;
    logic        sys_reset_reg;
    logic        ready_reg;
    logic        fault_reg;

    // Two-flop synchronisers for the asynchronous DCM status flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            locked_meta_reg <= 1'b0;
            locked_s        <= 1'b0;
            stop_meta_reg   <= 1'b0;
            stop_s          <= 1'b0;
        end else begin
            locked_meta_reg <= bus.dcm_locked;
            locked_s        <= locked_meta_reg;
            stop_meta_reg   <= bus.clkin_stopped;
            stop_s          <= stop_meta_reg;
        end
    end

    // A usable lock needs LOCKED high and the input clock running.
    assign lock_ok = locked_s && !stop_s;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        retries_next = retries_reg;
        loss_next    = loss_reg;

        if (bus.restart) begin
            // Restart overrides every other transition this cycle.
            state_next   = RESET_DCM;
            cnt_next     = '0;
            retries_next = '0;
        end else begin
            unique case (state_reg)
                RESET_DCM: begin
                    if (cnt_reg == RST_LAST) begin
                        state_next = WAIT_LOCK;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 16'd1;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_ok) begin
                        state_next = SETTLE;
                        cnt_next   = '0;
                    end else if (cnt_reg == LOCK_LAST) begin
                        cnt_next = '0;
                        if (retries_reg == RETRY_MAX) begin
                            state_next = FAULT;
                        end else begin
                            state_next   = RESET_DCM;
                            retries_next = retries_reg + 4'd1;
                        end
                    end else begin
                        cnt_next = cnt_reg + 16'd1;
                    end
                end
                SETTLE: begin
                    // A glitch here is not a timeout, so retries is kept.
                    if (!lock_ok) begin
                        state_next = RESET_DCM;
                        cnt_next   = '0;
                    end else if (cnt_reg == STABLE_LAST) begin
                        state_next   = RUN;
                        cnt_next     = '0;
                        retries_next = '0;
                    end else begin
                        cnt_next = cnt_reg + 16'd1;
                    end
                end
                RUN: begin
                    if (!lock_ok) begin
                        state_next = RESET_DCM;
                        cnt_next   = '0;
                        if (loss_reg != 8'hFF) begin
                            loss_next = loss_reg + 8'd1;
                        end
                    end
                end
                FAULT: begin
                    // Parked until restart or reset_n.
                end
                default: begin
                    state_next = RESET_DCM;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they move with the state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= RESET_DCM;
            cnt_reg       <= '0;
            retries_reg   <= '0;
            loss_reg      <= '0;
            dcm_rst_reg   <= 1'b1;
            sys_reset_reg <= 1'b1;
            ready_reg     <= 1'b0;
            fault_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            retries_reg   <= retries_next;
            loss_reg      <= loss_next;
            dcm_rst_reg   <= (state_next == RESET_DCM) || (state_next == FAULT);
            sys_reset_reg <= (state_next != RUN);
            ready_reg     <= (state_next == RUN);
            fault_reg     <= (state_next == FAULT);
        end
    end

    assign bus.dcm_rst    = dcm_rst_reg;
    assign bus.sys_reset  = sys_reset_reg;
    assign bus.ready      = ready_reg;
    assign bus.fault      = fault_reg;
    assign bus.loss_count = loss_reg;

endmodule

// File: tb/tb_dcm_reset_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dcm_reset_ctrl
// Self-checking bench for dcm_reset_ctrl with RST_CYCLES=4, LOCK_TIMEOUT=32,
// STABLE_CYCLES=8, MAX_RETRIES=2. A behavioural model tracks which phase the
// controller should be in using absolute deadlines, and every clock step
// compares the outputs against it; a vector table and hand-written sequences
// add fixed expectations for the bring-up and corner cases.
// ---------------------------------------------------------------------------
module tb_dcm_reset_ctrl;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 32;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 2;

    localparam int PH_PULSE  = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_SETTLE = 2;
    localparam int PH_RUN    = 3;
    localparam int PH_FAULT  = 4;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;

    dcm_reset_ctrl_if bus();

    dcm_reset_ctrl #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .MAX_RETRIES  (MAX_RETRIES)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    int         m_phase;
    int         m_end;
    int         m_cyc;
    int         m_timeouts;
    int         m_loss;
    logic [1:0] m_lk_line;
    logic [1:0] m_st_line;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_enter(input int ph);
        m_phase = ph;
        case (ph)
            PH_PULSE:  m_end = m_cyc + RST_CYCLES;
            PH_WAIT:   m_end = m_cyc + LOCK_TIMEOUT;
            PH_SETTLE: m_end = m_cyc + STABLE_CYCLES;
            default:   m_end = m_cyc;
        endcase
    endtask

    task automatic model_reset();
        m_cyc      = 0;
        m_timeouts = 0;
        m_loss     = 0;
        m_lk_line  = 2'b00;
        m_st_line  = 2'b00;
        model_enter(PH_PULSE);
    endtask

    // One rising edge: flags are seen two edges after they are sampled.
    task automatic model_step();
        logic good;
        if (!reset_n) begin
            model_reset();
            return;
        end
        m_cyc++;
        good      = m_lk_line[1] && !m_st_line[1];
        m_lk_line = {m_lk_line[0], bus.dcm_locked};
        m_st_line = {m_st_line[0], bus.clkin_stopped};
        if (bus.restart) begin
            m_timeouts = 0;
            model_enter(PH_PULSE);
        end else begin
            case (m_phase)
                PH_PULSE: if (m_cyc == m_end) model_enter(PH_WAIT);
                PH_WAIT: begin
                    if (good) model_enter(PH_SETTLE);
                    else if (m_cyc == m_end) begin
                        if (m_timeouts == MAX_RETRIES) model_enter(PH_FAULT);
                        else begin
                            m_timeouts++;
                            model_enter(PH_PULSE);
                        end
                    end
                end
                PH_SETTLE: begin
                    if (!good) model_enter(PH_PULSE);
                    else if (m_cyc == m_end) begin
                        m_timeouts = 0;
                        model_enter(PH_RUN);
                    end
                end
                PH_RUN: begin
                    if (!good) begin
                        if (m_loss < 255) m_loss++;
                        model_enter(PH_PULSE);
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_model();
        chk("model_dcm_rst", int'(bus.dcm_rst),
            int'(m_phase == PH_PULSE || m_phase == PH_FAULT));
        chk("model_sys_reset", int'(bus.sys_reset), int'(m_phase != PH_RUN));
        chk("model_ready", int'(bus.ready), int'(m_phase == PH_RUN));
        chk("model_fault", int'(bus.fault), int'(m_phase == PH_FAULT));
        chk("model_loss_count", int'(bus.loss_count), m_loss);
    endtask

    task automatic step();
        @(posedge clock);
        model_step();
        #1;
        check_model();
    endtask

    task automatic wait_ready(input int limit, input string name);
        int n = 0;
        while (!bus.ready && n < limit) begin
            step();
            n++;
        end
        chk(name, int'(bus.ready), 1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic lk;
        logic st;
        logic rs;
        int   n;
        logic e_dcm;
        logic e_sys;
        logic e_rdy;
        logic e_flt;
        int   e_loss;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_loss;
        int runs [$];
        int cur, len, n_ok, n_rdy;
        logic hit_fault;

        // Bring-up from reset, then a restart while running.
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 3,  1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 9,  1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 10, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b1, 1'b0, 0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 5,  1'b0, 1'b0, 1'b1, 1'b0, 0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1,  1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 3,  1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1,  1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 8,  1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b1, 1'b0, 0};

        bus.dcm_locked    = 1'b0;
        bus.clkin_stopped = 1'b0;
        bus.restart       = 1'b0;
        model_reset();

        // Reset state.
        #1 reset_n = 1'b0;
        #2;
        chk("reset_dcm_rst", int'(bus.dcm_rst), 1);
        chk("reset_sys_reset", int'(bus.sys_reset), 1);
        chk("reset_ready", int'(bus.ready), 0);
        chk("reset_fault", int'(bus.fault), 0);
        chk("reset_loss", int'(bus.loss_count), 0);
        repeat (3) step();
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            bus.dcm_locked    = tbl[i].lk;
            bus.clkin_stopped = tbl[i].st;
            bus.restart       = tbl[i].rs;
            repeat (tbl[i].n) step();
            chk($sformatf("row%0d_dcm_rst", i), int'(bus.dcm_rst), int'(tbl[i].e_dcm));
            chk($sformatf("row%0d_sys_reset", i), int'(bus.sys_reset), int'(tbl[i].e_sys));
            chk($sformatf("row%0d_ready", i), int'(bus.ready), int'(tbl[i].e_rdy));
            chk($sformatf("row%0d_fault", i), int'(bus.fault), int'(tbl[i].e_flt));
            chk($sformatf("row%0d_loss", i), int'(bus.loss_count), tbl[i].e_loss);
        end
        bus.restart = 1'b0;
        exp_loss = 0;

        // One-cycle lock loss in RUN: reaction on the third edge.
        bus.dcm_locked = 1'b0;
        step();
        bus.dcm_locked = 1'b1;
        step();
        chk("loss_still_run", int'(bus.sys_reset), 0);
        step();
        exp_loss++;
        chk("loss_sys_reset", int'(bus.sys_reset), 1);
        chk("loss_dcm_rst", int'(bus.dcm_rst), 1);
        chk("loss_count_inc", int'(bus.loss_count), exp_loss);
        wait_ready(40, "loss_relock");

        // Glitch while settling at cnt=5: back to reset, no ready pulse.
        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        n_rdy = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            n_rdy += int'(bus.ready);
        end
        bus.dcm_locked = 1'b0;
        step();
        n_rdy += int'(bus.ready);
        bus.dcm_locked = 1'b1;
        step();
        n_rdy += int'(bus.ready);
        chk("glitch_settle_dcm_rst", int'(bus.dcm_rst), 0);
        step();
        n_rdy += int'(bus.ready);
        chk("glitch_back_to_reset", int'(bus.dcm_rst), 1);
        chk("glitch_no_ready", n_rdy, 0);
        chk("glitch_loss_kept", int'(bus.loss_count), exp_loss);
        wait_ready(40, "glitch_relock");

        // Stopped input clock leaves RUN just like lock loss.
        bus.clkin_stopped = 1'b1;
        step();
        bus.clkin_stopped = 1'b0;
        step();
        chk("stop_still_run", int'(bus.ready), 1);
        step();
        exp_loss++;
        chk("stop_sys_reset", int'(bus.sys_reset), 1);
        chk("stop_dcm_rst", int'(bus.dcm_rst), 1);
        chk("stop_loss_inc", int'(bus.loss_count), exp_loss);
        wait_ready(40, "stop_relock");

        // Timeouts until fault: run lengths of dcm_rst high/low.
        bus.dcm_locked = 1'b0;
        bus.restart    = 1'b1;
        step();
        bus.restart = 1'b0;
        cur = int'(bus.dcm_rst);
        len = 1;
        hit_fault = 1'b0;
        for (int i = 0; i < 400 && !hit_fault; i++) begin
            step();
            if (bus.fault) begin
                hit_fault = 1'b1;
            end else if (int'(bus.dcm_rst) == cur) begin
                len++;
            end else begin
                runs.push_back(len);
                cur = int'(bus.dcm_rst);
                len = 1;
            end
        end
        runs.push_back(len);
        chk("timeout_fault_reached", int'(hit_fault), 1);
        chk("timeout_run_count", runs.size(), 6);
        for (int i = 0; i < runs.size() && i < 6; i++) begin
            chk($sformatf("timeout_run%0d_len", i), runs[i],
                (i % 2 == 0) ? RST_CYCLES : LOCK_TIMEOUT);
        end
        n_ok = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus.fault && bus.dcm_rst && !bus.ready) n_ok++;
        end
        chk("fault_held_100", n_ok, 100);

        // Recovery from fault with lock present.
        bus.dcm_locked = 1'b1;
        repeat (2) step();
        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        chk("recover_fault_cleared", int'(bus.fault), 0);
        repeat (3) step();
        chk("recover_rst_hold", int'(bus.dcm_rst), 1);
        step();
        chk("recover_rst_drop", int'(bus.dcm_rst), 0);
        wait_ready(30, "recover_ready");
        chk("recover_loss_kept", int'(bus.loss_count), exp_loss);

        // Asynchronous reset pulse between edges while running.
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("async_sys_reset", int'(bus.sys_reset), 1);
        chk("async_ready", int'(bus.ready), 0);
        chk("async_dcm_rst", int'(bus.dcm_rst), 1);
        chk("async_loss_clear", int'(bus.loss_count), 0);
        #2;
        reset_n = 1'b1;
        repeat (3) step();
        chk("async_seq_rst_hold", int'(bus.dcm_rst), 1);
        step();
        chk("async_seq_rst_drop", int'(bus.dcm_rst), 0);
        wait_ready(30, "async_relock");

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 6) bus.dcm_locked = ~bus.dcm_locked;
            bus.clkin_stopped = ($urandom_range(0, 199) == 0);
            bus.restart       = ($urandom_range(0, 299) == 0);
            step();
        end
        bus.clkin_stopped = 1'b0;
        bus.restart       = 1'b0;
        bus.dcm_locked    = 1'b1;
        wait_ready(200, "random_settle_ready");

        // 300 losses saturate the counter.
        for (int i = 0; i < 300; i++) begin
            bus.dcm_locked = 1'b0;
            step();
            bus.dcm_locked = 1'b1;
            repeat (2) step();
            wait_ready(40, "sat_relock");
        end
        chk("loss_saturated", int'(bus.loss_count), 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dcm_reset_ctrl.md
DCM_RESET_CTRL -- requirements
Module: dcm_reset_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 4: cycles dcm_rst is held high per DCM reset; legal range 3..255.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 1024: cycles to wait for lock after dcm_rst deasserts; legal range 2..65536.
REQ-003 SHALL have parameter STABLE_CYCLES, default 16: cycles lock must stay continuously high before release; legal range 1..65536.
REQ-004 SHALL have parameter MAX_RETRIES, default 7: timed-out lock attempts allowed before fault; legal range 0..15.
REQ-005 SHALL have port clock, input, 1: DCM input reference clock; all logic is on its rising edge.
REQ-006 SHALL have port reset_n, input, 1: reset, asynchronous assert, active-low.
REQ-007 SHALL have port dcm_locked, input, 1: DCM LOCKED; asynchronous to clock.
REQ-008 SHALL have port clkin_stopped, input, 1: DCM status clock-input-stopped flag; asynchronous to clock.
REQ-009 SHALL have port restart, input, 1: synchronous single-cycle request to restart the sequence.
REQ-010 SHALL have port dcm_rst, output, 1: drives DCM RST; high means the DCM is held in reset.
REQ-011 SHALL have port sys_reset, output, 1: active-high reset for the DCM-clocked system.
REQ-012 SHALL have port ready, output, 1: high only in RUN.
REQ-013 SHALL have port fault, output, 1: high only in FAULT.
REQ-014 SHALL have port loss_count, output, 8: number of lock losses from RUN; saturates at 255.

Function
REQ-015 SHALL pass dcm_locked and clkin_stopped through two-flop synchronisers (locked_s, stop_s) before any use; FSM sees input edges 2 cycles late.
REQ-016 SHALL implement states RESET_DCM, WAIT_LOCK, SETTLE, RUN and FAULT, using one 16-bit cycle counter cnt and a 4-bit retry counter retries.
REQ-017 In RESET_DCM, the block SHALL assert dcm_rst and count cycles; when cnt == RST_CYCLES-1 it SHALL go to WAIT_LOCK with cnt cleared.
REQ-018 In WAIT_LOCK, if locked_s is high and stop_s is low, the block SHALL go to SETTLE with cnt cleared.
REQ-019 In WAIT_LOCK, if cnt == LOCK_TIMEOUT-1 and retries == MAX_RETRIES, the block SHALL go to FAULT.
REQ-020 In WAIT_LOCK, if cnt == LOCK_TIMEOUT-1 and retries < MAX_RETRIES, the block SHALL increment retries and go to RESET_DCM with cnt cleared.
REQ-021 In SETTLE, if locked_s is low or stop_s is high, the block SHALL go to RESET_DCM without changing retries.
REQ-022 In SETTLE, otherwise, when cnt == STABLE_CYCLES-1 the block SHALL go to RUN and clear retries.
REQ-023 In RUN, if locked_s is low or stop_s is high, the block SHALL go to RESET_DCM and increment loss_count, saturating at 255.
REQ-024 In FAULT, the block SHALL hold dcm_rst high and SHALL leave FAULT only on restart or reset_n.
REQ-025 restart, in any state, SHALL force RESET_DCM with cnt and retries cleared and loss_count unchanged; restart SHALL take priority over every other transition in that cycle.
REQ-026 All outputs SHALL be registered, decoded from next-state, so they change on the same edge as the state: dcm_rst=1 in RESET_DCM/FAULT; sys_reset=0 only in RUN; ready=1 only in RUN; fault=1 only in FAULT.
REQ-027 When lock loss and timeout coincide, lock loss SHALL be evaluated per the current state only; no state SHALL take two transitions in one cycle.

Reset
REQ-028 While reset_n is low, the block SHALL immediately (asynchronously) set: state=RESET_DCM, cnt=0, retries=0, loss_count=0, both synchroniser stages=0, dcm_rst=1, sys_reset=1, ready=0, fault=0.
REQ-029 On reset_n deassertion, the block SHALL start the sequence at RESET_DCM cycle 0; reset_n asserted mid-RUN SHALL raise sys_reset without waiting for a clock.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-030 Normal bring-up: release reset_n, and raise dcm_locked 10 cycles after dcm_rst falls. Required: dcm_rst high exactly 4 cycles; sys_reset falls and ready rises 2+8 cycles after the locked edge.
REQ-031 Timeout to fault: dcm_locked held low. Required: three dcm_rst pulses of 4 cycles, each separated by 32 low cycles; fault=1 after the third timeout; state stays in FAULT for 100 cycles.
REQ-032 Recovery from fault: from FAULT, pulse restart with dcm_locked high. Required: dcm_rst pulses 4 cycles, ready=1 afterwards, loss_count unchanged.
REQ-033 Loss in RUN: drop dcm_locked for 1 cycle. Required: sys_reset=1 and dcm_rst=1 three cycles after the falling edge; loss_count goes 0->1; RUN re-reached after relock. With 300 losses, loss_count stays at 255.
REQ-034 Glitch in SETTLE and stop flag: drop lock at SETTLE cnt=5, then assert clkin_stopped in RUN. Required: return to RESET_DCM with retries unchanged and no ready pulse; clkin_stopped causes the same exit from RUN as lock loss.
REQ-035 Asynchronous reset mid-RUN: pulse reset_n low for 3 ns between clock edges. Required: sys_reset=1, ready=0 and dcm_rst=1 immediately; full RESET_DCM sequence follows.
